// File: rtl/brd_rst_seq.sv
// Board reset sequencer.
// Holds the PLLs in reset, waits for every PLL to report lock (with a
// bounded retry budget), then releases the downstream domain resets one
// stage at a time. Loss of lock sends everything back to PLL reset;
// running out of retries parks the block in FAULT until soft_rst or rst_n.
// Optional build macro BRD_RST_SEQ_LOCK_FILTER_EN: while releasing or
// running, lock loss is acted on only after 4 consecutive low cycles of
// the synchronised lock, so shorter glitches are ignored. Lock waiting is
// unaffected by the macro.
module brd_rst_seq #(
  parameter int NUM_PLL      = 2,
  parameter int NUM_CH       = 4,
  parameter int PLL_RST_CYC  = 16,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int STAGE_DLY    = 8,
  parameter int MAX_RETRY    = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_PLL-1:0] pll_lock,
  input  logic               soft_rst,
  output logic               pll_rst,
  output logic [NUM_CH-1:0]  ch_rst,
  output logic               all_ready,
  output logic               fault,
  output logic [3:0]         retry_cnt,
  output logic [2:0]         state
);

  typedef enum logic [2:0] {
    ST_PLL_RESET = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_RELEASE   = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_t;

  // One shared cycle counter covers every timed phase, so it is sized for
  // the longest of them.
  localparam int REL_CYC = NUM_CH * STAGE_DLY;
  localparam int MAX_AB  = (PLL_RST_CYC > LOCK_TIMEOUT) ? PLL_RST_CYC : LOCK_TIMEOUT;
  localparam int CNT_MAX = (MAX_AB > REL_CYC) ? MAX_AB : REL_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next, cnt_inc;
  logic [3:0]         retry_reg, retry_next, retry_inc;
  logic [NUM_PLL-1:0] sync1_reg, sync2_reg;
  logic               lock_ok;
  logic               lock_lost;
  logic               pll_rst_reg, pll_rst_next;
  logic [NUM_CH-1:0]  ch_rst_reg, ch_rst_next;
  logic               all_ready_reg, all_ready_next;
  logic               fault_reg, fault_next;

  // Two-flop synchroniser on the raw, asynchronous lock inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= pll_lock;
      sync2_reg <= sync1_reg;
    end
  end

  assign lock_ok = &sync2_reg;

`ifdef BRD_RST_SEQ_LOCK_FILTER_EN
  logic [1:0] lo_cnt_reg, lo_cnt_next;

  // Count consecutive low cycles of lock_ok, saturating at 3.
  always_comb begin
    lo_cnt_next = lo_cnt_reg;
    if (soft_rst || lock_ok) begin
      lo_cnt_next = 2'd0;
    end else if (lo_cnt_reg != 2'd3) begin
      lo_cnt_next = lo_cnt_reg + 2'd1;
    end
  end

  // Glitch-filter counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_cnt_reg <= 2'd0;
    end else begin
      lo_cnt_reg <= lo_cnt_next;
    end
  end

  // The current low cycle is the fourth in a row.
  assign lock_lost = !lock_ok && (lo_cnt_reg == 2'd3);
`else
  assign lock_lost = !lock_ok;
`endif

  assign cnt_inc   = (cnt_reg == '1) ? cnt_reg : cnt_reg + 1'b1;
  assign retry_inc = (retry_reg == 4'hF) ? retry_reg : retry_reg + 4'd1;

  // Next-state, counter and retry logic; soft_rst overrides everything.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_inc;
    retry_next = retry_reg;
    if (soft_rst) begin
      state_next = ST_PLL_RESET;
      cnt_next   = '0;
      retry_next = 4'd0;
    end else begin
      case (state_reg)
        ST_PLL_RESET: begin
          if (cnt_reg == CNT_W'(PLL_RST_CYC - 1)) begin
            state_next = ST_WAIT_LOCK;
            cnt_next   = '0;
          end
        end
        ST_WAIT_LOCK: begin
          // Timeout is checked first so it wins over a late lock.
          if (cnt_reg == CNT_W'(LOCK_TIMEOUT - 1)) begin
            retry_next = retry_inc;
            cnt_next   = '0;
            if (({1'b0, retry_reg} + 5'd1) < 5'(MAX_RETRY)) begin
              state_next = ST_PLL_RESET;
            end else begin
              state_next = ST_FAULT;
            end
          end else if (lock_ok) begin
            state_next = ST_RELEASE;
            cnt_next   = '0;
          end
        end
        ST_RELEASE: begin
          if (lock_lost) begin
            state_next = ST_PLL_RESET;
            cnt_next   = '0;
          end else if (cnt_reg == CNT_W'(REL_CYC - 1)) begin
            state_next = ST_RUN;
            cnt_next   = '0;
            retry_next = 4'd0;
          end
        end
        ST_RUN: begin
          cnt_next = '0;
          if (lock_lost) begin
            state_next = ST_PLL_RESET;
          end
        end
        ST_FAULT: begin
          cnt_next = '0;
        end
        default: begin
          state_next = ST_PLL_RESET;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Output values follow the state being entered, so the registered
  // outputs line up with the state register.
  always_comb begin
    pll_rst_next   = (state_next == ST_PLL_RESET) || (state_next == ST_FAULT);
    all_ready_next = (state_next == ST_RUN);
    fault_next     = (state_next == ST_FAULT);
  end

  // Channel gi is held until the release counter reaches (gi+1)*STAGE_DLY.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign ch_rst_next[gi] = (state_next == ST_RELEASE) ?
                               (cnt_next < CNT_W'((gi + 1) * STAGE_DLY)) :
                               (state_next != ST_RUN);
    end
  endgenerate

  // FSM, counters and all output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_PLL_RESET;
      cnt_reg       <= '0;
      retry_reg     <= 4'd0;
      pll_rst_reg   <= 1'b1;
      ch_rst_reg    <= '1;
      all_ready_reg <= 1'b0;
      fault_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      retry_reg     <= retry_next;
      pll_rst_reg   <= pll_rst_next;
      ch_rst_reg    <= ch_rst_next;
      all_ready_reg <= all_ready_next;
      fault_reg     <= fault_next;
    end
  end

  assign pll_rst   = pll_rst_reg;
  assign ch_rst    = ch_rst_reg;
  assign all_ready = all_ready_reg;
  assign fault     = fault_reg;
  assign retry_cnt = retry_reg;
  assign state     = state_reg;

endmodule

// File: tb/tb_brd_rst_seq.sv
// Testbench for brd_rst_seq: a phase/elapsed-time model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_brd_rst_seq;

  localparam int NP  = 2;
  localparam int NCH = 3;
  localparam int PRC = 8;
  localparam int LT  = 100;
  localparam int SD  = 4;
  localparam int MR  = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [NP-1:0]  pll_lock = '0;
  logic           soft_rst = 1'b0;
  logic           pll_rst;
  logic [NCH-1:0] ch_rst;
  logic           all_ready;
  logic           fault;
  logic [3:0]     retry_cnt;
  logic [2:0]     state;

  int total = 0;
  int bad   = 0;

  brd_rst_seq #(
    .NUM_PLL(NP), .NUM_CH(NCH), .PLL_RST_CYC(PRC),
    .LOCK_TIMEOUT(LT), .STAGE_DLY(SD), .MAX_RETRY(MR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock), .soft_rst(soft_rst),
    .pll_rst(pll_rst), .ch_rst(ch_rst), .all_ready(all_ready),
    .fault(fault), .retry_cnt(retry_cnt), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phase codes: 0 pll reset, 1 wait lock, 2 release, 3 run, 4 fault.
  int            m_mode = 0;
  int            m_el = 0;      // cycles since entering the phase
  int            m_retry = 0;
  int            m_low = 0;     // consecutive low cycles of synced lock
  logic [NP-1:0] m_s1 = '0;
  logic [NP-1:0] m_s2 = '0;

  function automatic void step(input int mode, input int el, input int rt,
                               input int low, input bit lk, input bit sr,
                               output int nm, output int ne, output int nr,
                               output int nl);
    bit lost;
    nm = mode; ne = el + 1; nr = rt;
    nl = lk ? 0 : ((low < 4) ? low + 1 : 4);
`ifdef BRD_RST_SEQ_LOCK_FILTER_EN
    lost = (nl >= 4);
`else
    lost = !lk;
`endif
    if (sr) begin
      nm = 0; ne = 0; nr = 0; nl = 0;
    end else if (mode == 0) begin
      if (el + 1 == PRC) begin nm = 1; ne = 0; end
    end else if (mode == 1) begin
      if (el + 1 == LT) begin
        nr = (rt < 15) ? rt + 1 : 15;
        nm = (nr < MR) ? 0 : 4;
        ne = 0;
      end else if (lk) begin
        nm = 2; ne = 0;
      end
    end else if (mode == 2) begin
      if (lost) begin nm = 0; ne = 0; end
      else if (el + 1 == NCH * SD) begin nm = 3; ne = 0; nr = 0; end
    end else if (mode == 3) begin
      ne = 0;
      if (lost) nm = 0;
    end else begin
      ne = 0;
    end
  endfunction

  function automatic int exp_ch(input int mode, input int el);
    int v;
    v = 0;
    for (int i = 0; i < NCH; i++) begin
      if (mode == 3) v = v;
      else if (mode == 2) v = v | (((el < (i + 1) * SD) ? 1 : 0) << i);
      else v = v | (1 << i);
    end
    return v;
  endfunction

  // Model update on each rising edge, reset asynchronously like the board.
  always @(posedge clk or negedge rst_n) begin : mdl
    int nm, ne, nr, nl;
    if (!rst_n) begin
      m_mode <= 0; m_el <= 0; m_retry <= 0; m_low <= 0;
      m_s1 <= '0; m_s2 <= '0;
    end else begin
      step(m_mode, m_el, m_retry, m_low, &m_s2, soft_rst, nm, ne, nr, nl);
      m_mode  <= nm;
      m_el    <= ne;
      m_retry <= nr;
      m_low   <= nl;
      m_s1    <= pll_lock;
      m_s2    <= m_s1;
    end
  end

  // Every-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    chk("m_pll_rst", int'(pll_rst), ((m_mode == 0) || (m_mode == 4)) ? 1 : 0);
    chk("m_ch_rst", int'(ch_rst), exp_ch(m_mode, m_el));
    chk("m_all_ready", int'(all_ready), (m_mode == 3) ? 1 : 0);
    chk("m_fault", int'(fault), (m_mode == 4) ? 1 : 0);
    chk("m_retry", int'(retry_cnt), m_retry);
    chk("m_state", int'(state), m_mode);
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input int st, input int maxc, output int n);
    n = 0;
    while ((int'(state) != st) && (n < maxc)) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (int'(state) != st) begin
      bad++;
      $display("FAIL wait_state: got state %0d expected %0d after %0d cycles",
               state, st, n);
    end
  endtask

  initial begin
    int n;
    #1 rst_n = 1'b0;
    tick(3);
    chk("rst_state", int'(state), 0);
    chk("rst_pll_rst", int'(pll_rst), 1);
    chk("rst_ch_rst", int'(ch_rst), 7);
    rst_n = 1'b1;

    // Normal bring-up: lock presented before edge 20.
    tick(7);
    chk("bring_pll_rst_e7", int'(pll_rst), 1);
    tick(1);
    chk("bring_pll_rst_e8", int'(pll_rst), 0);
    chk("bring_state_e8", int'(state), 1);
    tick(11);
    pll_lock = 2'b11;
    tick(3);
    chk("bring_release_entry", int'(state), 2);
    tick(3);
    chk("bring_ch_e25", int'(ch_rst), 7);
    tick(1);
    chk("bring_ch_e26", int'(ch_rst), 6);
    tick(4);
    chk("bring_ch_e30", int'(ch_rst), 4);
    tick(4);
    chk("bring_ch_e34", int'(ch_rst), 0);
    chk("bring_all_ready", int'(all_ready), 1);
    chk("bring_state_run", int'(state), 3);

    // One-cycle drop of lock[1] in RUN.
    pll_lock = 2'b01;
    tick(1);
    pll_lock = 2'b11;
    tick(1);
    chk("glitch_ch_a1", int'(ch_rst), 0);
    tick(1);
`ifdef BRD_RST_SEQ_LOCK_FILTER_EN
    chk("glitch_ch_a2", int'(ch_rst), 0);
    chk("glitch_state_a2", int'(state), 3);
`else
    chk("glitch_ch_a2", int'(ch_rst), 7);
    chk("glitch_state_a2", int'(state), 0);
    chk("glitch_ready_a2", int'(all_ready), 0);
`endif
    wait_state(3, 50, n);

    // Soft restart, then lock loss after channel 0 has cleared.
    soft_rst = 1'b1;
    tick(1);
    soft_rst = 1'b0;
    chk("soft_state", int'(state), 0);
    tick(13);
    chk("midrel_ch_before", int'(ch_rst), 6);
    pll_lock = 2'b00;
    tick(2);
    chk("midrel_ch_sync", int'(ch_rst), 6);
`ifdef BRD_RST_SEQ_LOCK_FILTER_EN
    tick(4);
`else
    tick(1);
`endif
    chk("midrel_ch_after", int'(ch_rst), 7);
    chk("midrel_state", int'(state), 0);

    // Lock held low: first timeout retries, second one faults.
    wait_state(1, 20, n);
    wait_state(0, 150, n);
    chk("wl_len1", n, 100);
    chk("retry1_cnt", int'(retry_cnt), 1);
    chk("retry1_pll_rst", int'(pll_rst), 1);
    wait_state(1, 20, n);
    wait_state(4, 150, n);
    chk("wl_len2", n, 100);
    chk("fault_flag", int'(fault), 1);
    chk("fault_pll_rst", int'(pll_rst), 1);
    chk("fault_ch", int'(ch_rst), 7);
    chk("fault_retry", int'(retry_cnt), 2);
    tick(5);
    chk("fault_sticky", int'(state), 4);
    soft_rst = 1'b1;
    tick(1);
    soft_rst = 1'b0;
    chk("fault_exit_state", int'(state), 0);
    chk("fault_exit_flag", int'(fault), 0);
    chk("fault_exit_retry", int'(retry_cnt), 0);

    // One timeout, then lock succeeds and RUN clears the retry count.
    wait_state(1, 20, n);
    wait_state(0, 150, n);
    chk("retry_then_lock_cnt", int'(retry_cnt), 1);
    pll_lock = 2'b11;
    wait_state(3, 100, n);
    chk("retry_then_lock_run_retry", int'(retry_cnt), 0);
    chk("retry_then_lock_ready", int'(all_ready), 1);

    // SOFT_RST on the same edge as a timeout.
    pll_lock = 2'b00;
    wait_state(0, 10, n);
    wait_state(1, 20, n);
    tick(99);
    soft_rst = 1'b1;
    tick(1);
    soft_rst = 1'b0;
    chk("collide_retry", int'(retry_cnt), 0);
    chk("collide_state", int'(state), 0);

    // Asynchronous reset in RUN, checked before any clock edge.
    pll_lock = 2'b11;
    wait_state(3, 100, n);
    #2 rst_n = 1'b0;
    #1;
    chk("async_state", int'(state), 0);
    chk("async_pll_rst", int'(pll_rst), 1);
    chk("async_ch", int'(ch_rst), 7);
    chk("async_ready", int'(all_ready), 0);
    chk("async_fault", int'(fault), 0);
    chk("async_retry", int'(retry_cnt), 0);
    tick(2);
    rst_n = 1'b1;
    wait_state(3, 100, n);
    tick(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/brd_rst_seq.md
BRD_RST_SEQ -- requirements
Module: brd_rst_seq

Interface
REQ-001 Parameter NUM_PLL, default 2: number of PLL lock inputs monitored, range 1..4.
REQ-002 Parameter NUM_CH, default 4: number of sequenced domain resets, range 1..8.
REQ-003 Parameter PLL_RST_CYC, default 16: PLL reset pulse width in CLK cycles, minimum 1.
REQ-004 Parameter LOCK_TIMEOUT, default 4096: maximum cycles allowed in WAIT_LOCK, minimum 2.
REQ-005 Parameter STAGE_DLY, default 8: cycles between consecutive channel releases, minimum 1.
REQ-006 Parameter MAX_RETRY, default 3: number of lock timeouts tolerated before FAULT, range 1..15.
REQ-007 CLK  in  1  sole clock; all state changes on its rising edge.
REQ-008 RST_N  in  1  asynchronous, active-low reset.
REQ-009 PLL_LOCK  in  NUM_PLL  raw PLL LOCKED outputs, asynchronous to CLK.
REQ-010 SOFT_RST  in  1  synchronous restart request, sampled high for one cycle.
REQ-011 PLL_RST  out  1  active-high reset to all PLLs.
REQ-012 CH_RST  out  NUM_CH  active-high per-domain resets; bit 0 is released first.
REQ-013 ALL_READY  out  1  high only in RUN.
REQ-014 FAULT  out  1  high only in FAULT.
REQ-015 RETRY_CNT  out  4  number of lock timeouts since the last RUN entry or restart.
REQ-016 STATE  out  3  state code: PLL_RESET=0, WAIT_LOCK=1, RELEASE=2, RUN=3, FAULT=4.

Function
REQ-017 Each PLL_LOCK bit SHALL pass through a 2-flop synchroniser; lock_ok is the AND of the synchronised bits.
REQ-018 All outputs SHALL be registered.
REQ-019 PLL_RESET: PLL_RST=1 and all CH_RST=1 for exactly PLL_RST_CYC cycles, then WAIT_LOCK with PLL_RST=0.
REQ-020 WAIT_LOCK transitions:
- lock_ok=1: RELEASE, with the cycle counter cleared.
- Cycle counter reaches LOCK_TIMEOUT and RETRY_CNT+1 < MAX_RETRY: increment RETRY_CNT, go to PLL_RESET.
- Cycle counter reaches LOCK_TIMEOUT otherwise: increment RETRY_CNT, go to FAULT.
REQ-021 RELEASE: CH_RST[i] SHALL deassert (i+1)*STAGE_DLY cycles after RELEASE entry, in order 0..NUM_CH-1.
REQ-022 RELEASE exit: the cycle the last bit clears, the FSM SHALL enter RUN and clear RETRY_CNT to 0.
REQ-023 RUN: ALL_READY=1 and CH_RST all 0; lock_ok=0 SHALL move the FSM to PLL_RESET, with all CH_RST=1 and ALL_READY=0 on the next edge.
REQ-024 Lock loss in RELEASE SHALL behave as in RUN; partially released channels SHALL be re-asserted.
REQ-025 FAULT: PLL_RST=1, CH_RST all 1, FAULT=1; the FSM SHALL leave FAULT only via SOFT_RST or RST_N.
REQ-026 SOFT_RST in any state SHALL go to PLL_RESET and clear RETRY_CNT and all counters.
REQ-027 SOFT_RST SHALL take priority over timeout and lock loss in the same cycle.
REQ-028 Timeout SHALL take priority over lock_ok rising in the same cycle.
REQ-029 Counters SHALL be sized by clog2 of their limit and SHALL saturate, never wrap.
REQ-030 RETRY_CNT SHALL saturate at 15.

Reset
REQ-031 On RST_N low, immediately and asynchronously:
- STATE=PLL_RESET, PLL_RST=1, CH_RST all 1;
- ALL_READY=0, FAULT=0, RETRY_CNT=0;
- counters and synchronisers cleared.
REQ-032 On RST_N deassertion, the PLL_RESET count SHALL begin on the first CLK edge.

Configuration
REQ-033 Macro BRD_RST_SEQ_LOCK_FILTER_EN, when defined: lock loss in RELEASE or RUN SHALL act only after lock_ok is low for 4 consecutive cycles; shorter glitches are ignored.
REQ-034 Without BRD_RST_SEQ_LOCK_FILTER_EN, a single low cycle of lock_ok in RELEASE or RUN SHALL act immediately.
REQ-035 The macro SHALL NOT affect WAIT_LOCK behaviour.

Verification
All scenarios use NUM_PLL=2, NUM_CH=3, PLL_RST_CYC=8, LOCK_TIMEOUT=100, STAGE_DLY=4, MAX_RETRY=2.
REQ-036 Normal bring-up: RST_N release, PLL_LOCK=2'b11 at cycle 20 -> PLL_RST falls at cycle 8; CH_RST releases at +4/+8/+12 cycles after RELEASE entry; ALL_READY=1.
REQ-037 Retry then lock: hold PLL_LOCK=0 -> timeout, RETRY_CNT=1, second PLL_RST pulse; lock then succeeds -> RUN with RETRY_CNT=0.
REQ-038 Fault: hold PLL_LOCK=0 -> after the second timeout FAULT=1, STATE=4, PLL_RST=1; a SOFT_RST pulse -> STATE=0, FAULT=0.
REQ-039 Lock loss: in RUN, drop PLL_LOCK[1] for 1 cycle -> all CH_RST=1 within 3 cycles; with BRD_RST_SEQ_LOCK_FILTER_EN defined, no reaction.
REQ-040 Collisions:
- Lock loss mid-RELEASE after CH_RST[0] has cleared -> CH_RST=3'b111.
- SOFT_RST in the same cycle as a timeout -> RETRY_CNT=0.
- RST_N low mid-RUN -> outputs match REQ-031 without a CLK edge.
